// File: rtl/softmax_ctrl_pkg.sv
// softmax_ctrl_pkg: shared FSM state type and width/latency constants
package softmax_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ACCUM, CHECK, NORM, OUT} state_e;
  function automatic int sum_w(input int n, input int a);
    return a + $clog2(n);
  endfunction
  function automatic int div_cycles(input int a);
    return 2 * a;
  endfunction
  localparam int INPUT_SIZE_DEF = 10;
  localparam int ACTIV_BITS_DEF = 8;
  localparam int SUM_W = sum_w(INPUT_SIZE_DEF, ACTIV_BITS_DEF);
  localparam int DIV_CYCLES = div_cycles(ACTIV_BITS_DEF);
endpackage

// File: rtl/softmax_ctrl_if.sv
// softmax_ctrl_if: input/output vector handshake bundle of the controller
interface softmax_ctrl_if #(
  parameter int INPUT_SIZE = 10,
  parameter int ACTIV_BITS = 8
);
  logic [INPUT_SIZE*ACTIV_BITS-1:0] in_data;
  logic [INPUT_SIZE*ACTIV_BITS-1:0] out_data;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic zero_sum;
  logic busy;
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, zero_sum, busy
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, zero_sum, busy
  );
endinterface

// File: rtl/softmax_div.sv
// softmax_div: restoring serial divider, one quotient bit per cycle
module softmax_div import softmax_ctrl_pkg::*; #(
  parameter int ACTIV_BITS = 8,
  parameter int SW = sum_w(10, 8)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2*ACTIV_BITS-1:0] dividend,
  input  logic [SW-1:0]           divisor,
  output logic [2*ACTIV_BITS-1:0] quotient,
  output logic                    done
);
  localparam int W  = 2 * ACTIV_BITS;
  localparam int DC = div_cycles(ACTIV_BITS);
  localparam int CW = $clog2(DC + 1);
  logic [SW-1:0] rem_q, rem_d, dvs_q, d_in, r_in;
  logic [W-1:0]  quo_q, quo_d, q_in;
  logic [SW:0]   trial;
  logic [CW-1:0] cnt_q;
  logic          ge, done_q;
  // The start cycle already performs the first step so done lands DC cycles after start
  always_comb begin
    r_in  = start ? '0 : rem_q;
    q_in  = start ? dividend : quo_q;
    d_in  = start ? divisor : dvs_q;
    trial = {r_in, q_in[W-1]};
    ge    = trial >= {1'b0, d_in};
    rem_d = ge ? SW'(trial - {1'b0, d_in}) : SW'(trial);
    quo_d = {q_in[W-2:0], ge};
  end
  // Shift/subtract state and the one-cycle done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= divisor;
        cnt_q <= CW'(DC - 1);
      end else if (cnt_q != '0) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        cnt_q  <= cnt_q - 1'b1;
        done_q <= cnt_q == CW'(1);
      end
    end
  end
  assign quotient = quo_q;
  assign done     = done_q;
endmodule

// File: rtl/softmax_ctrl.sv
// softmax_ctrl: latches a vector, sums it, and divides each element by the sum
module softmax_ctrl import softmax_ctrl_pkg::*; #(
  parameter int INPUT_SIZE = 10,
  parameter int ACTIV_BITS = 8
) (
  input logic          clk,
  input logic          rst,
  softmax_ctrl_if.slave bus
);
  localparam int SW = sum_w(INPUT_SIZE, ACTIV_BITS);
  localparam int VW = INPUT_SIZE * ACTIV_BITS;
  localparam int IW = INPUT_SIZE > 1 ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IW-1:0] LAST = IW'(INPUT_SIZE - 1);
  state_e                  st_q;
  logic [VW-1:0]           vec_q, res_q;
  logic [SW-1:0]           sum_q;
  logic [IW-1:0]           idx_q;
  logic                    in_ready_q, out_valid_q, zero_q, busy_q, start_q, done;
  logic [2*ACTIV_BITS-1:0] quo;
  logic [ACTIV_BITS-1:0]   elem, sat;
  assign elem = vec_q[int'(idx_q)*ACTIV_BITS +: ACTIV_BITS];
  assign sat  = |quo[2*ACTIV_BITS-1:ACTIV_BITS] ? '1 : quo[ACTIV_BITS-1:0];
  softmax_div #(.ACTIV_BITS(ACTIV_BITS), .SW(SW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start_q),
    .dividend ({elem, {ACTIV_BITS{1'b0}}}),
    .divisor  (sum_q),
    .quotient (quo),
    .done     (done)
  );
  // Control FSM; every handshake/status output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      vec_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (st_q)
        IDLE:
          if (in_ready_q && bus.in_valid) begin
            vec_q      <= bus.in_data;
            sum_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            st_q       <= ACCUM;
          end else
            in_ready_q <= 1'b1;
        ACCUM: begin
          sum_q <= sum_q + SW'(elem);
          idx_q <= idx_q == LAST ? '0 : idx_q + 1'b1;
          if (idx_q == LAST) st_q <= CHECK;
        end
        CHECK:
          if (sum_q == '0) begin
            res_q       <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b1;
            st_q        <= OUT;
          end else begin
            zero_q  <= 1'b0;
            idx_q   <= '0;
            start_q <= 1'b1;
            st_q    <= NORM;
          end
        NORM:
          if (done) begin
            res_q[int'(idx_q)*ACTIV_BITS +: ACTIV_BITS] <= sat;
            if (idx_q == LAST) begin
              out_valid_q <= 1'b1;
              st_q        <= OUT;
            end else begin
              idx_q   <= idx_q + 1'b1;
              start_q <= 1'b1;
            end
          end
        OUT:
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            st_q        <= IDLE;
          end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = res_q;
  assign bus.zero_sum  = zero_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_softmax_ctrl.sv
// tb_softmax_ctrl: directed and random vectors checked against an arithmetic model
module tb_softmax_ctrl;
  localparam int N = 10;
  localparam int A = 8;
  localparam int W = N * A;
  localparam int LAT = N + 2 + N * (2 * A + 1);
  localparam int ZLAT = N + 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] v;
  softmax_ctrl_if #(.INPUT_SIZE(N), .ACTIV_BITS(A)) bus ();
  softmax_ctrl #(.INPUT_SIZE(N), .ACTIV_BITS(A)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W:0] model(input logic [W-1:0] x);
    logic [W-1:0] r = '0;
    int s = 0;
    int q;
    for (int i = 0; i < N; i++) s += int'(x[i*A +: A]);
    if (s == 0) return {1'b1, r};
    for (int i = 0; i < N; i++) begin
      q = (int'(x[i*A +: A]) * (1 << A)) / s;
      r[i*A +: A] = q > (1 << A) - 1 ? A'((1 << A) - 1) : A'(q);
    end
    return {1'b0, r};
  endfunction
  function automatic logic [W-1:0] rand_vec(input int zero_pct);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++)
      r[i*A +: A] = ($urandom_range(0, 99) < zero_pct) ? '0 : A'($urandom_range(0, (1 << A) - 1));
    return r;
  endfunction
  function automatic logic [W-1:0] fill(input int x);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*A +: A] = A'(x);
    return r;
  endfunction
  task automatic run(input logic [W-1:0] x, input bit scramble, input int hold);
    logic [W:0] m;
    int cyc, acc, t;
    m = model(x);
    cyc = 0;
    acc = 0;
    t = 0;
    while (!bus.in_ready && t < 10) begin
      tick();
      t++;
    end
    chk("ready_before_send", W'(bus.in_ready), W'(1));
    bus.in_data = x;
    bus.in_valid = 1'b1;
    tick();
    cyc = 1;
    if (!scramble) bus.in_valid = 1'b0;
    while (!bus.out_valid && cyc < LAT + 20) begin
      if (scramble) bus.in_data = rand_vec(0);
      acc += int'(bus.in_ready);
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("latency", W'(cyc), W'(m[W] ? ZLAT : LAT));
    chk("out_data", bus.out_data, m[W-1:0]);
    chk("zero_sum", W'(bus.zero_sum), W'(m[W]));
    if (scramble) chk("no_reaccept", W'(acc), W'(0));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_data", bus.out_data, m[W-1:0]);
      chk("hold_zero", W'(bus.zero_sum), W'(m[W]));
      chk("hold_flags", W'({bus.out_valid, bus.in_ready, bus.busy}), W'(3'b101));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("after_out", W'({bus.out_valid, bus.in_ready, bus.busy}), W'(3'b010));
  endtask
  initial begin
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("reset_flags", W'({bus.in_ready, bus.out_valid, bus.busy, bus.zero_sum}), W'(0));
    chk("reset_data", bus.out_data, W'(0));
    rst = 1'b0;
    tick();
    chk("ready_after_release", W'(bus.in_ready), W'(1));
    run('0, 1'b0, 0);
    v = '0;
    v[A-1:0] = A'(200);
    run(v, 1'b0, 0);
    run(fill(10), 1'b0, 5);
    run(fill(255), 1'b0, 0);
    run(rand_vec(20), 1'b1, 0);
    bus.in_data = fill(10);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c < 50; c++) tick();
    chk("norm_flags", W'({bus.out_valid, bus.busy}), W'(2'b01));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_flags", W'({bus.out_valid, bus.busy, bus.in_ready}), W'(0));
    tick();
    chk("mid_reset_ready", W'(bus.in_ready), W'(1));
    run(fill(10), 1'b0, 0);
    for (int k = 0; k < 6; k++) run(rand_vec(k * 15), 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/softmax_ctrl.md
SOFTMAX_CTRL -- requirements
Module: softmax_ctrl

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 10: number of activations per vector.
REQ-002 SHALL have parameter ACTIV_BITS, default 8: activation width, unsigned.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, INPUT_SIZE*ACTIV_BITS bits: input vector, element i at [i*ACTIV_BITS +: ACTIV_BITS].
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: controller accepts a vector.
REQ-008 SHALL have port out_data, output, INPUT_SIZE*ACTIV_BITS bits: normalized vector, same packing as in_data.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-011 SHALL have port zero_sum, output, 1 bit: input sum was 0; meaningful while out_valid is high.
REQ-012 SHALL have port busy, output, 1 bit: high in any state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, CHECK, NORM, OUT.
REQ-014 IDLE: in_ready=1; when in_valid is high, SHALL latch in_data into a vector register, clear the sum and index, and go to ACCUM.
REQ-015 in_ready SHALL be 0 in every state other than IDLE; vectors do not overlap.
REQ-016 ACCUM: SHALL add one element per cycle, index 0..INPUT_SIZE-1, into a sum of width SUM_W = ACTIV_BITS + clog2(INPUT_SIZE); after INPUT_SIZE cycles, go to CHECK.
REQ-017 CHECK, 1 cycle: if sum==0, SHALL clear every result element, set zero_sum=1 and go to OUT; otherwise set zero_sum=0 and go to NORM with index=0.
REQ-018 NORM: for each element, SHALL pulse div start for 1 cycle, then wait for div done.
REQ-019 The division SHALL compute q = (x_i << ACTIV_BITS) / sum, with a 2*ACTIV_BITS-bit dividend, a SUM_W-bit divisor and a floor quotient.
REQ-020 The stored result SHALL be min(q, 2^ACTIV_BITS-1).
REQ-021 Each element SHALL take exactly 2*ACTIV_BITS+1 cycles; after the last element, go to OUT.
REQ-022 Latency: counting the handshake cycle as 0, out_valid SHALL first be high in cycle INPUT_SIZE+2+INPUT_SIZE*(2*ACTIV_BITS+1), which is 182 at the defaults.
REQ-023 For a zero sum, out_valid SHALL first be high in cycle INPUT_SIZE+2, which is 12 at the defaults.
REQ-024 OUT: out_valid=1 and out_data/zero_sum SHALL be held stable while out_ready=0.
REQ-025 On out_valid&&out_ready in OUT, SHALL go to IDLE; in_ready is 1 in the following cycle.
REQ-026 in_valid SHALL be ignored outside IDLE.
REQ-027 Changes to in_data after the handshake SHALL have no effect on the result.
REQ-028 out_valid SHALL be 0 in all states except OUT.

Reset
REQ-029 While rst is high at a clock edge, the FSM SHALL go to IDLE.
REQ-030 Reset values: in_ready=0 during reset and 1 in the cycle after release; out_valid=0; out_data=0; zero_sum=0; busy=0; sum=0; index=0.
REQ-031 The divider SHALL be cleared by rst, with its done signal at 0.
REQ-032 A reset during ACCUM, NORM or OUT SHALL abandon the vector with no partial output.
REQ-033 The next accepted vector after such a reset SHALL produce a correct result.

Structure
REQ-034 The shared package SHALL hold the FSM state enum and the SUM_W / DIV_CYCLES = 2*ACTIV_BITS width and latency constants.
REQ-035 The division SHALL be a single sub-module, softmax_div, used for all elements.
REQ-036 softmax_div SHALL be a restoring serial divider with ports start, dividend, divisor, quotient and done.
REQ-037 softmax_div done SHALL pulse for 1 cycle exactly DIV_CYCLES cycles after start.

Verification
REQ-038 All-zero vector -> zero_sum=1, out_data=0, out_valid first high in cycle 12.
REQ-039 x0=200, all others 0 -> sum=200, q0=256 saturated to 255, others 0, zero_sum=0, out_valid in cycle 182.
REQ-040 All elements 10 -> sum=100, every output 2560/100=25; all elements 255 -> sum=2550, every output 65280/2550=25.
REQ-041 Hold out_ready=0 for 5 cycles in OUT -> out_data/zero_sum stable, in_ready=0, busy=1; raise out_ready -> in_ready=1 in the next cycle.
REQ-042 Pulse rst in cycle 50 (during NORM) -> next cycle out_valid=0, busy=0, in_ready=1 after release; then send the all-10 vector -> every output 25.
REQ-043 Hold in_valid high and change in_data during ACCUM/NORM -> no second accept, result matches the latched vector.
